clint_timer: RTL and testbench

Core-local interrupt source for the machine-mode CSR unit: it holds the memory-mapped `msip`, `mtimecmp` and `mtime` registers and drives the `trint`, `swint` and `exint` interrupt levels that the CSR unit samples in the memory stage. It is a slave on the data-bus fabric, selected by the address decoder for the CLINT window, and answers loads and stores with a two-phase handshake: `addr_ok` then `data_ok`.

---
 rtl/clint_pkg.sv | 18 +
 rtl/clint_sync2.sv | 12 +
 rtl/clint_timer.sv | 78 +++++++
 tb/tb_clint_timer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, bus FSM states and latched request type for clint_timer
package clint_pkg;
  localparam logic [15:0] CLINT_MSIP     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
  localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;
  typedef enum logic {IDLE, RESP} clint_state_t;
  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] wdata;
  } clint_req_t;
  function automatic logic [63:0] merge64(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] sb);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = sb[i] ? wd[i*8 +: 8] : old[i*8 +: 8];
    return r;
  endfunction
endpackage

// File: rtl/clint_sync2.sv
// clint_sync2: two-flop synchronizer for an asynchronous level input
module clint_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic s;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {q, s} <= 2'b00;
    else {q, s} <= {s, d};
endmodule

// File: rtl/clint_timer.sv
// clint_timer: CLINT msip/mtimecmp/mtime bus slave with timer/software/external interrupt levels.
// Define CLINT_EXT_SYNC_EN to pass ext_irq through a two-flop synchronizer before the output register.
module clint_timer
  import clint_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  input  logic        ext_irq,
  output logic        trint,
  output logic        swint,
  output logic        exint
);
  clint_state_t state, state_nx;
  clint_req_t   req;
  logic [63:0]  mtime, mtimecmp, rel;
  logic [10:0]  pcnt;
  logic         msip, tick, in_win, hit_msip, hit_cmp, hit_time, commit, ext_in;
  assign rel      = req.addr - BASE_ADDR;
  assign in_win   = rel[63:16] == 48'd0;
  assign hit_msip = in_win && rel[15:0] == CLINT_MSIP;
  assign hit_cmp  = in_win && rel[15:0] == CLINT_MTIMECMP;
  assign hit_time = in_win && rel[15:0] == CLINT_MTIME;
  assign commit   = data_ok && req.write;
  assign tick     = pcnt == 11'(PRESCALE - 1);
  // addr_ok is gated by reset so every output is quiet while reset is held
  always_comb begin
    state_nx = IDLE;
    addr_ok  = 1'b0;
    data_ok  = 1'b0;
    if (state == IDLE) begin
      addr_ok  = req_valid && reset_n;
      state_nx = req_valid ? RESP : IDLE;
    end else data_ok = 1'b1;
  end
  assign resp_err   = data_ok && !(hit_msip || hit_cmp || hit_time);
  assign resp_rdata = (data_ok && !req.write) ?
                      (hit_msip ? {63'd0, msip} : hit_cmp ? mtimecmp : hit_time ? mtime : 64'd0) : 64'd0;
`ifdef CLINT_EXT_SYNC_EN
  clint_sync2 u_sync (.clk(clk), .reset_n(reset_n), .d(ext_irq), .q(ext_in));
`else
  assign ext_in = ext_irq;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      req      <= '0;
      pcnt     <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      msip     <= 1'b0;
      trint    <= 1'b0;
      swint    <= 1'b0;
      exint    <= 1'b0;
    end else begin
      state <= state_nx;
      if (addr_ok) req <= '{write: req_write, addr: req_addr, strobe: req_strobe, wdata: req_wdata};
      pcnt  <= tick ? 11'd0 : pcnt + 11'd1;
      // a store to mtime overrides that cycle's increment
      mtime <= (commit && hit_time) ? merge64(mtime, req.wdata, req.strobe) : tick ? mtime + 64'd1 : mtime;
      if (commit && hit_cmp) mtimecmp <= merge64(mtimecmp, req.wdata, req.strobe);
      if (commit && hit_msip && req.strobe[0]) msip <= req.wdata[0];
      trint <= mtime >= mtimecmp;
      swint <= msip;
      exint <= ext_in;
    end
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: two instances (PRESCALE 1 and 4) on a shared bus, checked against a behavioural register model
module tb_clint_timer;
  import clint_pkg::*;
  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
`ifdef CLINT_EXT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 1'b0, reset_n = 1'b0, req_valid = 1'b0, req_write = 1'b0, ext_irq = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [7:0]  req_strobe = '0;
  logic [1:0]  addr_ok, data_ok, resp_err, trint, swint, exint;
  logic [63:0] rdata [2];
  int          total = 0, bad = 0;
  int unsigned ecnt;
  logic [63:0] m_time [2];
  logic [63:0] m_cmp;
  logic        m_msip;
  logic [1:0]  e_tr, e_sw, e_ex;
  logic [2:0]  hist;

  always #5 clk = ~clk;

  clint_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_strobe(req_strobe), .req_wdata(req_wdata), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]),
    .resp_rdata(rdata[0]), .resp_err(resp_err[0]), .ext_irq(ext_irq), .trint(trint[0]),
    .swint(swint[0]), .exint(exint[0]));
  clint_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_strobe(req_strobe), .req_wdata(req_wdata), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]),
    .resp_rdata(rdata[1]), .resp_err(resp_err[1]), .ext_irq(ext_irq), .trint(trint[1]),
    .swint(swint[1]), .exint(exint[1]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bmerge(input logic [63:0] o, input logic [63:0] w, input logic [7:0] s);
    logic [63:0] m = '0;
    for (int i = 0; i < 8; i++) if (s[i]) m |= 64'hFF << (8 * i);
    return (o & ~m) | (w & m);
  endfunction

  function automatic int presc(input int i);
    return i == 0 ? 1 : 4;
  endfunction

  task automatic reset_model();
    ecnt = 0;
    m_time[0] = '0;
    m_time[1] = '0;
    m_cmp = '1;
    m_msip = 1'b0;
    e_tr = '0;
    e_sw = '0;
    e_ex = '0;
    hist = '0;
  endtask

  // one rising edge; st/off/sb/wd describe a store committing on this edge
  task automatic step(input logic st, input logic [15:0] off, input logic [7:0] sb, input logic [63:0] wd);
    @(posedge clk);
    ecnt++;
    for (int i = 0; i < 2; i++) e_tr[i] = m_time[i] >= m_cmp;
    e_sw = {2{m_msip}};
    hist = {hist[1:0], ext_irq};
    e_ex = {2{hist[LAT-1]}};
    for (int i = 0; i < 2; i++)
      if (st && off == CLINT_MTIME) m_time[i] = bmerge(m_time[i], wd, sb);
      else if (ecnt % presc(i) == 0) m_time[i] = m_time[i] + 64'd1;
    if (st && off == CLINT_MTIMECMP) m_cmp = bmerge(m_cmp, wd, sb);
    if (st && off == CLINT_MSIP && sb[0]) m_msip = wd[0];
    #1;
    chk("trint", 64'(trint), 64'(e_tr));
    chk("swint", 64'(swint), 64'(e_sw));
    chk("exint", 64'(exint), 64'(e_ex));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 16'h0, 8'h0, 64'h0);
  endtask

  task automatic access(input logic wr, input logic [15:0] off, input logic [7:0] sb, input logic [63:0] wd);
    logic        mapped;
    logic [63:0] exp [2];
    mapped = off == CLINT_MSIP || off == CLINT_MTIMECMP || off == CLINT_MTIME;
    req_valid = 1'b1;
    req_write = wr;
    req_addr = BASE + {48'd0, off};
    req_strobe = sb;
    req_wdata = wd;
    #1;
    chk("addr_ok_idle", 64'(addr_ok), 64'h3);
    chk("data_ok_idle", 64'(data_ok), 64'h0);
    step(1'b0, 16'h0, 8'h0, 64'h0);
    for (int i = 0; i < 2; i++)
      exp[i] = (wr || !mapped) ? 64'd0 : off == CLINT_MSIP ? {63'd0, m_msip} :
               off == CLINT_MTIMECMP ? m_cmp : m_time[i];
    chk("addr_ok_resp", 64'(addr_ok), 64'h0);
    chk("data_ok_resp", 64'(data_ok), 64'h3);
    chk("resp_err", 64'(resp_err), {62'd0, {2{!mapped}}});
    chk("rdata_p1", rdata[0], exp[0]);
    chk("rdata_p4", rdata[1], exp[1]);
    step(wr && mapped, off, sb, wd);
    req_valid = 1'b0;
  endtask

  initial begin
    reset_model();
    #2;
    chk("rst_outputs", {58'd0, addr_ok, data_ok, trint}, 64'd0);
    chk("rst_irqs", {60'd0, swint, exint}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(10);
    access(1'b0, CLINT_MTIME, 8'h00, 64'd0);
    access(1'b1, CLINT_MTIMECMP, 8'hFF, 64'h20);
    idle(140);
    access(1'b1, CLINT_MTIMECMP, 8'hFF, '1);
    idle(3);
    access(1'b1, CLINT_MSIP, 8'hFF, 64'd1);
    idle(2);
    access(1'b1, CLINT_MSIP, 8'hFF, 64'd0);
    idle(2);
    access(1'b1, CLINT_MSIP, 8'hFF, 64'hFFFF);
    access(1'b0, CLINT_MSIP, 8'h00, 64'd0);
    access(1'b1, CLINT_MTIME, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE);
    access(1'b0, CLINT_MTIME, 8'h00, 64'd0);
    idle(8);
    access(1'b0, CLINT_MTIME, 8'h00, 64'd0);
    while ((ecnt + 2) % 4 != 0) idle(1);
    access(1'b1, CLINT_MTIME, 8'h0F, 64'h1234);
    access(1'b0, CLINT_MTIME, 8'h00, 64'd0);
    access(1'b0, 16'h0100, 8'h00, 64'd0);
    access(1'b1, 16'h0100, 8'hFF, 64'hDEAD);
    access(1'b1, CLINT_MTIMECMP, 8'h00, 64'd0);
    for (int k = 0; k < 8; k++) begin
      ext_irq = ~ext_irq;
      idle(k % 4 + 1);
    end
    for (int k = 0; k < 60; k++) begin
      logic [15:0] offs [5];
      offs = '{CLINT_MSIP, CLINT_MTIMECMP, CLINT_MTIME, 16'h0100, 16'h8000};
      ext_irq = 1'($urandom);
      access(1'($urandom), offs[$urandom_range(0, 4)],
             ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom), {$urandom, $urandom} >> $urandom_range(0, 60));
      idle($urandom_range(0, 3));
    end
    access(1'b1, CLINT_MSIP, 8'h01, 64'd1);
    ext_irq = 1'b1;
    idle(4);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = BASE + {48'd0, CLINT_MTIME};
    #1;
    step(1'b0, 16'h0, 8'h0, 64'h0);
    reset_n = 1'b0;
    #1;
    chk("midrst_bus", {58'd0, addr_ok, data_ok, resp_err}, 64'd0);
    chk("midrst_rdata", rdata[0] | rdata[1], 64'd0);
    chk("midrst_irq", {58'd0, trint, swint, exint}, 64'd0);
    req_valid = 1'b0;
    reset_model();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 16'h0, 8'h0, 64'h0);
    chk("post_rst_data_ok", 64'(data_ok), 64'd0);
    idle(2);
    access(1'b0, CLINT_MTIME, 8'h00, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
